chain_mixer_sequencer: RTL and testbench

Parametrised timing controller for a serial chain of N two-input mixers. Stage s mixes the running stream j[s] with reagent k[s] and produces j[s+1]. The block accepts one run command through a valid/ready handshake and steps a configurable contiguous range of stages. For each stage it opens the reagent valve, actuates the mixer, then transfers the product downstream, each phase lasting a programmed number of cycles. It sits between the host command interface and the valve/actuator drivers of a chain mixer netlist.

---
 rtl/chain_mixer_sequencer_pkg.sv | 44 ++++
 rtl/chain_mixer_sequencer_if.sv | 36 +++
 rtl/chain_mixer_sequencer_dwell_timer.sv | 40 ++++
 rtl/chain_mixer_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_chain_mixer_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/chain_mixer_sequencer_pkg.sv
// Shared definitions for the chain mixer sequencer: FSM state encoding,
// the widened run-command record and the command legality check.
package chain_mixer_pkg;

   localparam int MAX_SW    = 16;
   localparam int MAX_CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      DOSE = 3'd1,
      MIX  = 3'd2,
      XFER = 3'd3,
      DONE = 3'd4
   } seq_state_t;

   typedef struct packed {
      logic [MAX_SW-1:0]    first;
      logic [MAX_SW-1:0]    last;
      logic [MAX_CNT_W-1:0] dose;
      logic [MAX_CNT_W-1:0] mix;
      logic [MAX_CNT_W-1:0] xfer;
   } seq_cmd_t;

   // A run is legal when its stage range is ordered, lies inside the chain
   // and every phase lasts at least one cycle.
   function automatic logic cmd_is_legal(input seq_cmd_t cmd, input logic [31:0] n_stages);
      logic ok;
      if (cmd.first > cmd.last) begin
         ok = 1'b0;
      end else if ({{(32-MAX_SW){1'b0}}, cmd.last} >= n_stages) begin
         ok = 1'b0;
      end else if (cmd.dose == {MAX_CNT_W{1'b0}}) begin
         ok = 1'b0;
      end else if (cmd.mix == {MAX_CNT_W{1'b0}}) begin
         ok = 1'b0;
      end else if (cmd.xfer == {MAX_CNT_W{1'b0}}) begin
         ok = 1'b0;
      end else begin
         ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/chain_mixer_sequencer_if.sv
// Host command / valve driver bundle of the chain mixer sequencer.
// master = command source and valve driver side, slave = the sequencer.
interface chain_mixer_sequencer_if #(
   parameter int N_STAGES = 128,
   parameter int CNT_W    = 16
);
   localparam int SW = $clog2(N_STAGES);

   logic                cmd_valid;
   logic                cmd_ready;
   logic [SW-1:0]       cmd_first;
   logic [SW-1:0]       cmd_last;
   logic [CNT_W-1:0]    cmd_dose;
   logic [CNT_W-1:0]    cmd_mix;
   logic [CNT_W-1:0]    cmd_xfer;
   logic                abort;
   logic [N_STAGES-1:0] reagent_en;
   logic [N_STAGES-1:0] mix_en;
   logic [N_STAGES-1:0] xfer_en;
   logic                busy;
   logic [SW-1:0]       stage;
   logic                done;
   logic                aborted;
   logic                err;

   modport master (
      output cmd_valid, cmd_first, cmd_last, cmd_dose, cmd_mix, cmd_xfer, abort,
      input  cmd_ready, reagent_en, mix_en, xfer_en, busy, stage, done, aborted, err
   );

   modport slave (
      input  cmd_valid, cmd_first, cmd_last, cmd_dose, cmd_mix, cmd_xfer, abort,
      output cmd_ready, reagent_en, mix_en, xfer_en, busy, stage, done, aborted, err
   );

endinterface

// File: rtl/chain_mixer_sequencer_dwell_timer.sv
// Loadable phase-length down-counter. The count holds the number of cycles
// left in the current phase including the present one, so expiry is flagged
// while the count reads one and a reload can follow with no gap cycle.
module dwell_timer #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Reload has priority; decrement never goes below zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (en && (count_q != {CNT_W{1'b0}})) begin
         count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= {CNT_W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/chain_mixer_sequencer.sv
// Timing controller for a chain of two-input mixers. Steps a contiguous
// stage range through reagent dose, mix and transfer phases. All outputs
// except cmd_ready are registered from the next-state values, so they line
// up with the state they describe.
module chain_mixer_sequencer #(
   parameter int N_STAGES = 128,
   parameter int CNT_W    = 16
) (
   input logic                    clk,
   input logic                    rst_n,
   chain_mixer_sequencer_if.slave bus
);
   import chain_mixer_pkg::*;

   localparam int SW = $clog2(N_STAGES);

   seq_state_t          state_q, state_d;
   logic [SW-1:0]       stage_q, stage_d;
   logic [SW-1:0]       last_q, last_d;
   logic [CNT_W-1:0]    dose_q, dose_d;
   logic [CNT_W-1:0]    mix_q, mix_d;
   logic [CNT_W-1:0]    xfer_q, xfer_d;
   logic [N_STAGES-1:0] reagent_en_q, reagent_en_d;
   logic [N_STAGES-1:0] mix_en_q, mix_en_d;
   logic [N_STAGES-1:0] xfer_en_q, xfer_en_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                aborted_q, aborted_d;
   logic                err_q, err_d;

   seq_cmd_t            cmd_s;
   logic                legal_s;
   logic                accept_s;
   logic                active_s;
   logic                tmr_load_s;
   logic                tmr_en_s;
   logic [CNT_W-1:0]    tmr_val_s;
   logic                tmr_expired_s;

   function automatic logic [N_STAGES-1:0] stage_onehot(input logic [SW-1:0] idx);
      return {{(N_STAGES-1){1'b0}}, 1'b1} << idx;
   endfunction

   dwell_timer #(.CNT_W(CNT_W)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_s),
      .en       (tmr_en_s),
      .load_val (tmr_val_s),
      .expired  (tmr_expired_s)
   );

   assign bus.cmd_ready = (state_q == IDLE) && !bus.abort;
   assign accept_s      = bus.cmd_valid && bus.cmd_ready;
   assign legal_s       = cmd_is_legal(cmd_s, N_STAGES);
   assign active_s      = (state_q == DOSE) || (state_q == MIX) || (state_q == XFER);

   // Widen the offered command into the package record for the legality check.
   always_comb begin
      cmd_s       = {$bits(seq_cmd_t){1'b0}};
      cmd_s.first = MAX_SW'(bus.cmd_first);
      cmd_s.last  = MAX_SW'(bus.cmd_last);
      cmd_s.dose  = MAX_CNT_W'(bus.cmd_dose);
      cmd_s.mix   = MAX_CNT_W'(bus.cmd_mix);
      cmd_s.xfer  = MAX_CNT_W'(bus.cmd_xfer);
   end

   // Next-state logic: phase sequencing, stage stepping and timer reloads.
   always_comb begin
      state_d    = state_q;
      stage_d    = stage_q;
      last_d     = last_q;
      dose_d     = dose_q;
      mix_d      = mix_q;
      xfer_d     = xfer_q;
      tmr_load_s = 1'b0;
      tmr_en_s   = 1'b0;
      tmr_val_s  = dose_q;
      case (state_q)
         IDLE: begin
            if (accept_s && legal_s) begin
               state_d    = DOSE;
               stage_d    = bus.cmd_first;
               last_d     = bus.cmd_last;
               dose_d     = bus.cmd_dose;
               mix_d      = bus.cmd_mix;
               xfer_d     = bus.cmd_xfer;
               tmr_load_s = 1'b1;
               tmr_val_s  = bus.cmd_dose;
            end else begin
               stage_d = {SW{1'b0}};
            end
         end
         DOSE: begin
            if (bus.abort) begin
               state_d = IDLE;
               stage_d = {SW{1'b0}};
            end else if (tmr_expired_s) begin
               state_d    = MIX;
               tmr_load_s = 1'b1;
               tmr_val_s  = mix_q;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         MIX: begin
            if (bus.abort) begin
               state_d = IDLE;
               stage_d = {SW{1'b0}};
            end else if (tmr_expired_s) begin
               state_d    = XFER;
               tmr_load_s = 1'b1;
               tmr_val_s  = xfer_q;
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         XFER: begin
            if (bus.abort) begin
               state_d = IDLE;
               stage_d = {SW{1'b0}};
            end else if (tmr_expired_s) begin
               if (stage_q == last_q) begin
                  state_d = DONE;
               end else begin
                  state_d    = DOSE;
                  stage_d    = stage_q + {{(SW-1){1'b0}}, 1'b1};
                  tmr_load_s = 1'b1;
                  tmr_val_s  = dose_q;
               end
            end else begin
               tmr_en_s = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = {SW{1'b0}};
         end
         default: begin
            state_d = IDLE;
            stage_d = {SW{1'b0}};
         end
      endcase
   end

   // Output decode from the next state so the registered outputs match it.
   always_comb begin
      reagent_en_d = {N_STAGES{1'b0}};
      mix_en_d     = {N_STAGES{1'b0}};
      xfer_en_d    = {N_STAGES{1'b0}};
      case (state_d)
         DOSE:    reagent_en_d = stage_onehot(stage_d);
         MIX:     mix_en_d     = stage_onehot(stage_d);
         XFER:    xfer_en_d    = stage_onehot(stage_d);
         default: reagent_en_d = {N_STAGES{1'b0}};
      endcase
      busy_d    = (state_d == DOSE) || (state_d == MIX) || (state_d == XFER);
      done_d    = (state_d == DONE);
      aborted_d = active_s && bus.abort;
      err_d     = accept_s && !legal_s;
   end

   // State, stage and latched command registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stage_q <= {SW{1'b0}};
         last_q  <= {SW{1'b0}};
         dose_q  <= {CNT_W{1'b0}};
         mix_q   <= {CNT_W{1'b0}};
         xfer_q  <= {CNT_W{1'b0}};
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         last_q  <= last_d;
         dose_q  <= dose_d;
         mix_q   <= mix_d;
         xfer_q  <= xfer_d;
      end
   end

   // Registered valve enables and status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reagent_en_q <= {N_STAGES{1'b0}};
         mix_en_q     <= {N_STAGES{1'b0}};
         xfer_en_q    <= {N_STAGES{1'b0}};
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         reagent_en_q <= reagent_en_d;
         mix_en_q     <= mix_en_d;
         xfer_en_q    <= xfer_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         err_q        <= err_d;
      end
   end

   assign bus.reagent_en = reagent_en_q;
   assign bus.mix_en     = mix_en_q;
   assign bus.xfer_en    = xfer_en_q;
   assign bus.busy       = busy_q;
   assign bus.stage      = stage_q;
   assign bus.done       = done_q;
   assign bus.aborted    = aborted_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_chain_mixer_sequencer.sv
// Bench for chain_mixer_sequencer: an 8-stage instance checked cycle by
// cycle against an expected-output queue built from each command, plus a
// 6-stage / 4-bit instance for the range limit and full-length durations.
module tb_chain_mixer_sequencer;

   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   int   done_cyc = -1;

   chain_mixer_sequencer_if #(.N_STAGES(8), .CNT_W(16)) bus_a ();
   chain_mixer_sequencer_if #(.N_STAGES(6), .CNT_W(4))  bus_b ();

   chain_mixer_sequencer #(.N_STAGES(8), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   chain_mixer_sequencer #(.N_STAGES(6), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   typedef struct packed {
      logic       ready;
      logic [7:0] re;
      logic [7:0] me;
      logic [7:0] xe;
      logic       busy;
      logic [2:0] stage;
      logic       done;
      logic       aborted;
      logic       err;
   } obs_t;

   typedef struct {
      int first; int last; int dose; int mix; int xfer;
      bit err;   int len;
   } vec_t;

   obs_t exp_q[$];
   vec_t vecs[7];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
      end
   endtask

   function automatic obs_t idle_obs(input logic rdy);
      obs_t o;
      o = '0;
      o.ready = rdy;
      return o;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.ready   = bus_a.cmd_ready;
      o.re      = bus_a.reagent_en;
      o.me      = bus_a.mix_en;
      o.xe      = bus_a.xfer_en;
      o.busy    = bus_a.busy;
      o.stage   = bus_a.stage;
      o.done    = bus_a.done;
      o.aborted = bus_a.aborted;
      o.err     = bus_a.err;
      return o;
   endfunction

   // Scoreboard: one expected record per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) chk("seq", get_obs(), exp_q.pop_front());
      if (bus_a.done) done_cyc <= cyc;
   end

   // Expected per-cycle trace of one command, from its accept cycle on.
   task automatic push_run(input vec_t v, input bit lead, input int abort_at);
      obs_t o;
      int   k;
      bit   stop;
      k    = 0;
      stop = 1'b0;
      if (lead) exp_q.push_back(idle_obs(1'b1));
      if (v.err) begin
         o = idle_obs(1'b1);
         o.err = 1'b1;
         exp_q.push_back(o);
      end else begin
         for (int s = v.first; s <= v.last && !stop; s++) begin
            for (int ph = 0; ph < 3 && !stop; ph++) begin
               int n;
               n = (ph == 0) ? v.dose : (ph == 1) ? v.mix : v.xfer;
               for (int c = 0; c < n && !stop; c++) begin
                  o = idle_obs(1'b0);
                  o.busy  = 1'b1;
                  o.stage = 3'(s);
                  if (ph == 0)      o.re = 8'b1 << s;
                  else if (ph == 1) o.me = 8'b1 << s;
                  else              o.xe = 8'b1 << s;
                  exp_q.push_back(o);
                  if (k == abort_at) begin
                     stop = 1'b1;
                     o = idle_obs(1'b1);
                     o.aborted = 1'b1;
                     exp_q.push_back(o);
                  end
                  k++;
               end
            end
         end
         if (!stop) begin
            o = idle_obs(1'b0);
            o.stage = 3'(v.last);
            o.done  = 1'b1;
            exp_q.push_back(o);
         end
      end
      exp_q.push_back(idle_obs(1'b1));
   endtask

   task automatic drive_a(input vec_t v);
      bus_a.cmd_first = 3'(v.first);
      bus_a.cmd_last  = 3'(v.last);
      bus_a.cmd_dose  = 16'(v.dose);
      bus_a.cmd_mix   = 16'(v.mix);
      bus_a.cmd_xfer  = 16'(v.xfer);
   endtask

   // Offer one command for one cycle; returns in the first cycle after accept.
   task automatic send(input vec_t v, input int abort_at);
      @(posedge clk); #1;
      drive_a(v);
      bus_a.cmd_valid = 1'b1;
      push_run(v, 1'b1, abort_at);
      acc_cyc = cyc;
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1);
   end

   initial begin
      vec_t va, vb;
      int   n_re, n_me, n_xe, k;

      vecs[0] = '{2, 4, 3, 5, 2, 1'b0, 30};
      vecs[1] = '{7, 7, 1, 1, 1, 1'b0, 3};
      vecs[2] = '{5, 3, 1, 1, 1, 1'b1, 0};
      vecs[3] = '{0, 0, 4, 0, 2, 1'b1, 0};
      vecs[4] = '{0, 0, 0, 1, 1, 1'b1, 0};
      vecs[5] = '{1, 2, 2, 1, 3, 1'b0, 12};
      vecs[6] = '{0, 1, 1, 1, 0, 1'b1, 0};

      rst_n = 1'b0;
      bus_a.cmd_valid = 1'b0; bus_a.abort = 1'b0;
      bus_a.cmd_first = 3'd0; bus_a.cmd_last = 3'd0;
      bus_a.cmd_dose = 16'd0; bus_a.cmd_mix = 16'd0; bus_a.cmd_xfer = 16'd0;
      bus_b.cmd_valid = 1'b0; bus_b.abort = 1'b0;
      bus_b.cmd_first = 3'd0; bus_b.cmd_last = 3'd0;
      bus_b.cmd_dose = 4'd0; bus_b.cmd_mix = 4'd0; bus_b.cmd_xfer = 4'd0;

      repeat (3) @(posedge clk);
      #1 chk("reset_state", get_obs(), idle_obs(1'b1));
      @(negedge clk) rst_n = 1'b1;

      // Table of commands: legal runs, ordering/zero-duration rejections.
      for (int i = 0; i < 7; i++) begin
         send(vecs[i], -1);
         drain();
         if (!vecs[i].err) chk("run_len", done_cyc - acc_cyc, 1 + vecs[i].len);
      end

      // Abort during MIX of stage 3 (run 2..4, dose 2, mix 4, xfer 2).
      va = '{2, 4, 2, 4, 2, 1'b0, 24};
      send(va, 11);
      repeat (11) @(posedge clk);
      #1 bus_a.abort = 1'b1;
      @(posedge clk); #1;
      bus_a.abort = 1'b0;
      drain();

      // abort together with cmd_valid in IDLE: command must be refused.
      @(posedge clk); #1;
      drive_a(vecs[1]);
      bus_a.cmd_valid = 1'b1;
      bus_a.abort     = 1'b1;
      exp_q.push_back(idle_obs(1'b0));
      exp_q.push_back(idle_obs(1'b1));
      exp_q.push_back(idle_obs(1'b1));
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
      bus_a.abort     = 1'b0;
      drain();

      // Back-to-back: valid held with a second command queued behind.
      va = '{1, 1, 1, 2, 1, 1'b0, 4};
      vb = '{6, 7, 1, 1, 2, 1'b0, 8};
      @(posedge clk); #1;
      drive_a(va);
      bus_a.cmd_valid = 1'b1;
      push_run(va, 1'b1, -1);
      push_run(vb, 1'b0, -1);
      acc_cyc = cyc;
      @(posedge clk); #1;
      drive_a(vb);
      k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus_a.cmd_ready) break;
         k++;
      end
      chk("b2b_ready_wait", k, 5);
      @(posedge clk); #1;
      bus_a.cmd_valid = 1'b0;
      drain();
      chk("b2b_done", done_cyc - acc_cyc, 15);

      // Asynchronous reset in XFER of stage 1, then a fresh run.
      va = '{0, 2, 2, 2, 3, 1'b0, 21};
      send(va, -1);
      repeat (12) @(posedge clk);
      #1 chk("mid_xfer", bus_a.xfer_en, 8'h02);
      #1;
      exp_q.delete();
      rst_n = 1'b0;
      #1 chk("async_rst", get_obs(), idle_obs(1'b1));
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      send(vecs[0], -1);
      drain();
      chk("post_rst_len", done_cyc - acc_cyc, 31);

      // 6-stage instance: last = N_STAGES is rejected.
      @(posedge clk); #1;
      bus_b.cmd_first = 3'd0; bus_b.cmd_last = 3'd6;
      bus_b.cmd_dose = 4'd1; bus_b.cmd_mix = 4'd1; bus_b.cmd_xfer = 4'd1;
      bus_b.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.cmd_valid = 1'b0;
      @(negedge clk);
      chk("b_err", {bus_b.err, bus_b.busy, bus_b.reagent_en}, {1'b1, 1'b0, 6'h00});
      @(negedge clk);
      chk("b_err_pulse", {bus_b.err, bus_b.busy}, 2'b00);

      // 6-stage instance: 4-bit durations of 15 run fully on stage 5.
      @(posedge clk); #1;
      bus_b.cmd_first = 3'd5; bus_b.cmd_last = 3'd5;
      bus_b.cmd_dose = 4'd15; bus_b.cmd_mix = 4'd1; bus_b.cmd_xfer = 4'd15;
      bus_b.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus_b.cmd_valid = 1'b0;
      n_re = 0; n_me = 0; n_xe = 0; k = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         k++;
         if (bus_b.reagent_en == 6'b100000) n_re++;
         if (bus_b.mix_en == 6'b100000)     n_me++;
         if (bus_b.xfer_en == 6'b100000)    n_xe++;
         if (bus_b.done) break;
      end
      chk("b_dose_cycles", n_re, 15);
      chk("b_mix_cycles", n_me, 1);
      chk("b_xfer_cycles", n_xe, 15);
      chk("b_done_at", k, 32);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
